// File: rtl/register_file_pkg.sv
// Shared sizing for the decode-stage register file and its valid scoreboard.
// Register 0 is architecturally zero; REG_ZERO names its index.
package register_file_pkg;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS);

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/register_file.sv
// 32x32 register file with a per-register valid scoreboard; async read, write/reserve at the clock edge.
// Latency: read is combinational (returns pre-edge state), updates land at posedge; no backpressure, decode stalls on flagOutput=0.
module register_file
  import register_file_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] index,
  input  logic [DATA_W-1:0] valueInput,
  output logic [DATA_W-1:0] valueOutput,
  input  logic              readEnable,
  input  logic              writeEnable,
  output logic              flagOutput,
  input  logic              reserveEnable,
  input  logic [ADDR_W-1:0] reserveIndex
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] flag_q;
  logic [NUM_REGS-1:0] flag_d;

  // Reserve is applied after the write so a newer producer keeps ownership of the register.
  always_comb begin
    regs_d = regs_q;
    flag_d = flag_q;
    if (writeEnable && (index != REG_ZERO)) begin
      regs_d[index] = valueInput;
      flag_d[index] = 1'b1;
    end
    if (reserveEnable && (reserveIndex != REG_ZERO)) begin
      flag_d[reserveIndex] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      flag_q <= '1;
    end else begin
      regs_q <= regs_d;
      flag_q <= flag_d;
    end
  end

  // r0 is never updated, so it reads back as zero with flag set without a special case.
  always_comb begin
    valueOutput = '0;
    flagOutput  = 1'b1;
    if (readEnable) begin
      valueOutput = regs_q[index];
      flagOutput  = flag_q[index];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed and randomized checks of register_file against an array-based reference model.
module tb_register_file;
  import register_file_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] index;
  logic [DATA_W-1:0] valueInput;
  logic [DATA_W-1:0] valueOutput;
  logic              readEnable;
  logic              writeEnable;
  logic              flagOutput;
  logic              reserveEnable;
  logic [ADDR_W-1:0] reserveIndex;

  register_file dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .index        (index),
    .valueInput   (valueInput),
    .valueOutput  (valueOutput),
    .readEnable   (readEnable),
    .writeEnable  (writeEnable),
    .flagOutput   (flagOutput),
    .reserveEnable(reserveEnable),
    .reserveIndex (reserveIndex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W-1:0] m_regs [NUM_REGS];
  logic              m_flag [NUM_REGS];

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) begin
      m_regs[i] = '0;
      m_flag[i] = 1'b1;
    end
  endtask

  // Advance one rising edge, applying the architectural rules to the model, and return at the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      if (writeEnable && index != 0) begin
        m_regs[index] = valueInput;
        m_flag[index] = 1'b1;
      end
      if (reserveEnable && reserveIndex != 0) m_flag[reserveIndex] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    writeEnable   = 1'b0;
    reserveEnable = 1'b0;
    readEnable    = 1'b1;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] i);
    index = i;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    index = '0; valueInput = '0; readEnable = 1'b1; writeEnable = 1'b0;
    reserveEnable = 1'b0; reserveIndex = '0;
    model_reset();
    #2;
    chk("reset_async_val", valueOutput, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < NUM_REGS; i++) begin
      rd(i[ADDR_W-1:0]);
      chk($sformatf("reset_val_r%0d", i), valueOutput, 32'h0);
      chk($sformatf("reset_flag_r%0d", i), {31'b0, flagOutput}, 32'h1);
    end

    // Write r5; same-cycle read shows the old value.
    index = 5; valueInput = 32'hDEADBEEF; writeEnable = 1'b1;
    #1;
    chk("r5_same_cycle_old", valueOutput, 32'h0);
    step();
    idle();
    rd(5);
    chk("r5_after_write", valueOutput, 32'hDEADBEEF);
    chk("r5_flag", {31'b0, flagOutput}, 32'h1);

    readEnable = 1'b0;
    #1;
    chk("read_disabled_val", valueOutput, 32'h0);
    chk("read_disabled_flag", {31'b0, flagOutput}, 32'h1);
    readEnable = 1'b1;

    // Writes and reserves to r0 are ignored.
    index = 0; valueInput = 32'h12345678; writeEnable = 1'b1;
    reserveEnable = 1'b1; reserveIndex = 0;
    step();
    idle();
    rd(0);
    chk("r0_val", valueOutput, 32'h0);
    chk("r0_flag", {31'b0, flagOutput}, 32'h1);

    reserveEnable = 1'b1; reserveIndex = 7;
    step();
    idle();
    rd(7);
    chk("r7_reserved_flag", {31'b0, flagOutput}, 32'h0);
    reserveEnable = 1'b1; reserveIndex = 7;
    step();
    idle();
    rd(7);
    chk("r7_rereserve_flag", {31'b0, flagOutput}, 32'h0);
    index = 7; valueInput = 32'h0000_00A5; writeEnable = 1'b1;
    step();
    idle();
    rd(7);
    chk("r7_write_val", valueOutput, 32'hA5);
    chk("r7_write_flag", {31'b0, flagOutput}, 32'h1);

    // Same-register write+reserve: data lands, flag ends pending.
    index = 9; valueInput = 32'h55; writeEnable = 1'b1;
    reserveEnable = 1'b1; reserveIndex = 9;
    step();
    idle();
    rd(9);
    chk("r9_val", valueOutput, 32'h55);
    chk("r9_flag", {31'b0, flagOutput}, 32'h0);

    index = 3; valueInput = 32'h3333; writeEnable = 1'b1;
    reserveEnable = 1'b1; reserveIndex = 4;
    step();
    idle();
    rd(3);
    chk("r3_val", valueOutput, 32'h3333);
    chk("r3_flag", {31'b0, flagOutput}, 32'h1);
    rd(4);
    chk("r4_flag", {31'b0, flagOutput}, 32'h0);

    // Asynchronous reset mid-cycle clears state before the next edge.
    index = 2; valueInput = 32'hFFFF_FFFF; writeEnable = 1'b1;
    step();
    idle();
    rd(2);
    chk("r2_before_reset", valueOutput, 32'hFFFF_FFFF);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("r2_async_reset", valueOutput, 32'h0);
    for (int i = 0; i < NUM_REGS; i++) begin
      rd(i[ADDR_W-1:0]);
      chk($sformatf("async_flag_r%0d", i), {31'b0, flagOutput}, 32'h1);
    end

    // Updates presented while reset is held are discarded.
    index = 6; valueInput = 32'hCAFE; writeEnable = 1'b1;
    reserveEnable = 1'b1; reserveIndex = 6;
    step();
    idle();
    rst_n = 1'b1;
    rd(6);
    chk("r6_discarded_val", valueOutput, 32'h0);
    chk("r6_discarded_flag", {31'b0, flagOutput}, 32'h1);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      index         = ADDR_W'($urandom_range(0, NUM_REGS-1));
      valueInput    = $urandom;
      writeEnable   = ($urandom_range(0, 2) == 0);
      reserveEnable = ($urandom_range(0, 3) == 0);
      reserveIndex  = ($urandom_range(0, 3) == 0) ? index : ADDR_W'($urandom_range(0, NUM_REGS-1));
      readEnable    = ($urandom_range(0, 7) != 0);
      #1;
      chk($sformatf("rand%0d_val_r%0d", n, index), valueOutput,
          readEnable ? m_regs[index] : 32'h0);
      chk($sformatf("rand%0d_flag_r%0d", n, index), {31'b0, flagOutput},
          {31'b0, (readEnable ? m_flag[index] : 1'b1)});
      step();
    end

    idle();
    for (int i = 0; i < NUM_REGS; i++) begin
      rd(i[ADDR_W-1:0]);
      chk($sformatf("final_val_r%0d", i), valueOutput, m_regs[i]);
      chk($sformatf("final_flag_r%0d", i), {31'b0, flagOutput}, {31'b0, m_flag[i]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
